// File: rtl/seq_add_pkg.sv
// seq_add_pkg: shared state encoding, chunk-count helper and width-check macro for seq_add
`define SEQ_ADD_WIDTH_CHECK(dw, cw) \
  if ((dw) % (cw) != 0) begin : g_width_err \
    $error("seq_add: DATAWIDTH must be a multiple of CHUNKWIDTH"); \
  end

package seq_add_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic int nchunk(input int dw, input int cw);
    return dw / cw;
  endfunction
endpackage

// File: rtl/add_chunk.sv
// add_chunk: combinational CHUNKWIDTH-bit adder with carry in/out
module add_chunk #(
  parameter int CHUNKWIDTH = 8
) (
  input  logic [CHUNKWIDTH-1:0] x,
  input  logic [CHUNKWIDTH-1:0] y,
  input  logic                  cin,
  output logic [CHUNKWIDTH-1:0] s,
  output logic                  co
);
  assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNKWIDTH{1'b0}}, cin};
endmodule

// File: rtl/seq_add.sv
// seq_add: multi-cycle chunked adder, LSB chunk first, valid/ready on both sides.
// Optional signed overflow output ovf enabled by SEQ_ADD_OVF_EN.
module seq_add
  import seq_add_pkg::*;
#(
  parameter int DATAWIDTH  = 32,
  parameter int CHUNKWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] sum,
  output logic                 cout
`ifdef SEQ_ADD_OVF_EN
  ,
  output logic                 ovf
`endif
);
  localparam int NCHUNK = nchunk(DATAWIDTH, CHUNKWIDTH);
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  `SEQ_ADD_WIDTH_CHECK(DATAWIDTH, CHUNKWIDTH)
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic carry, co, last;
  logic [DATAWIDTH-1:0] a_q, b_q;
  logic [CHUNKWIDTH-1:0] x, y, s;
  assign x = a_q[idx*CHUNKWIDTH +: CHUNKWIDTH];
  assign y = b_q[idx*CHUNKWIDTH +: CHUNKWIDTH];
  assign last = idx == IW'(NCHUNK - 1);
  assign in_ready = state == ST_IDLE;
  add_chunk #(.CHUNKWIDTH(CHUNKWIDTH)) u_add (.x(x), .y(y), .cin(carry), .s(s), .co(co));
  always_comb begin
    state_n = state;
    state_n = (state == ST_IDLE && in_valid) ? ST_RUN :
              (state == ST_RUN && last)      ? ST_DONE :
              (state == ST_DONE && out_ready) ? ST_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      out_valid <= state_n == ST_DONE;
      if (state == ST_IDLE && in_valid) begin
        a_q   <= a;
        b_q   <= b;
        idx   <= '0;
        carry <= 1'b0;
      end
      if (state == ST_RUN) begin
        sum[idx*CHUNKWIDTH +: CHUNKWIDTH] <= s;
        carry <= co;
        idx   <= last ? '0 : idx + IW'(1);
        if (last) cout <= co;
`ifdef SEQ_ADD_OVF_EN
        // the top chunk's MSB is the result sign bit
        if (last) ovf <= (a_q[DATAWIDTH-1] == b_q[DATAWIDTH-1]) && (s[CHUNKWIDTH-1] != a_q[DATAWIDTH-1]);
`endif
      end
    end
  end
endmodule

// File: doc/seq_add.md
Name: seq_add

Overview:
- Multi-cycle chunked adder: the additive counterpart of the datapath subtractor.
- Computes sum = a + b with carry-out, processing CHUNKWIDTH bits per clock, LSB chunk first.
- Operand and result sides each use a valid/ready handshake.
- Sits in the datapath library next to the combinational arithmetic blocks; used where area matters more than latency.

Parameters:
- DATAWIDTH, 32, operand and result width in bits.
- CHUNKWIDTH, 8, bits added per cycle. DATAWIDTH % CHUNKWIDTH must be 0, otherwise elaboration error.
- NCHUNK (localparam), DATAWIDTH/CHUNKWIDTH, number of RUN cycles.

Ports:
- Clk  input  1  single clock, rising edge.
- Rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  DATAWIDTH  operand A, unsigned.
- b  input  DATAWIDTH  operand B, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- sum  output  DATAWIDTH  a + b mod 2^DATAWIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow; present only with SEQ_ADD_OVF_EN.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - RUN: chunk counter idx 0..NCHUNK-1.
  - DONE: out_valid=1.
- Reset (Rst high at a rising edge):
  - state=IDLE, idx=0, carry=0.
  - sum=0, cout=0, out_valid=0, ovf=0.
  - Captured operands cleared.
  - Applies in any state; an operation in flight is discarded with no output.
- in_ready = (state==IDLE), combinational from state. out_valid = (state==DONE), registered.
- IDLE -> RUN:
  - Taken on an edge with in_valid && in_ready.
  - a and b are captured into internal registers; idx=0, carry=0.
  - Input changes after capture have no effect.
- RUN, each edge:
  - {c, s} = a_q[idx chunk] + b_q[idx chunk] + carry.
  - s is written to sum[idx*CHUNKWIDTH +: CHUNKWIDTH]; carry <= c; idx++.
  - On idx==NCHUNK-1: cout <= c, state -> DONE.
- Latency:
  - Accept edge T, first edge where out_valid=1 is T+NCHUNK.
  - Out_valid is observed during cycle T+NCHUNK → T+NCHUNK+1.
  - CHUNKWIDTH==DATAWIDTH gives one RUN cycle.
- DONE:
  - sum, cout and ovf are held stable until out_valid && out_ready at an edge, then state -> IDLE.
  - No operand accept on that same edge; the next accept is possible one cycle later.
  - Throughput: one op per NCHUNK+2 cycles.
- in_valid while busy (RUN/DONE): ignored, not queued.
- sum is partially updated during RUN; it is only meaningful when out_valid=1.
- Arithmetic: unsigned modulo 2^DATAWIDTH. No saturation.

Optional Feature:
- Macro: SEQ_ADD_OVF_EN.
- Defined:
  - Port ovf exists.
  - On entry to DONE, ovf <= (a_q[MSB]==b_q[MSB]) && (result MSB != a_q[MSB]).
  - ovf is held with sum and cleared by reset.
- Undefined: port and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package/include seq_add_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Chunk-count function (ceil-free, DATAWIDTH/CHUNKWIDTH) and the width-check macro.
- Sub-module add_chunk:
  - Combinational CHUNKWIDTH-bit adder, inputs x, y, cin; outputs s, co.
  - Instantiated once; the FSM muxes slices into it.

Test Plan (DATAWIDTH=32, CHUNKWIDTH=8, NCHUNK=4):
- Basic add: accept a=0x00000001, b=0x00000002 at edge T -> out_valid first high after edge T+4; sum=0x00000003, cout=0; in_ready=0 from T to handshake.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, cout=1. a=0x12345678, b=0x0FEDCBA9 -> sum=0x22222221, cout=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE, with in_valid=1 and new operands -> sum/cout stable, in_ready=0, new operands not captured; out_ready=1 -> IDLE next edge, in_ready=1.
- Mid-operation reset: assert Rst during RUN idx=2 -> after that edge state IDLE, sum=0, cout=0, out_valid=0, in_ready=1; next op a=5, b=7 yields 12 correctly.
- Operand capture: change a, b every cycle during RUN -> result equals captured pair only.
- Overflow (SEQ_ADD_OVF_EN): 0x7FFFFFFF+1 -> sum=0x80000000, cout=0, ovf=1. 0x80000000+0x80000000 -> sum=0, cout=1, ovf=1. 0xFFFFFFFF+1 -> ovf=0. Rebuild without macro: ovf port absent, same sums.
